serv_csr_seq: RTL

//  Sequencer for the bit-serial CSR/trap datapath. Accepts one instruction-boundary request, arbitrates

---
 rtl/serv_csr_seq_pkg.sv | 25 ++
 rtl/serv_csr_seq_if.sv | 36 +++
 rtl/serv_csr_bitcnt.sv | 40 ++++
 rtl/serv_csr_seq.sv | 95 +++++++++
 4 files changed

// File: rtl/serv_csr_seq_pkg.sv
// Shared definitions for the CSR/trap serial-word sequencer: state encoding and
// word-geometry helpers derived from the serial width W.
package serv_csr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSR  = 2'd1,
        ST_TRAP = 2'd2,
        ST_MRET = 2'd3
    } state_t;

    localparam int W_DEFAULT   = 1;
    localparam int WORD_CYCLES = 32 / W_DEFAULT;
    localparam int CNT_LAST    = 32 - W_DEFAULT;

    function automatic int word_cycles(input int w);
        return 32 / w;
    endfunction

    // Bit index of the final chunk of a word for a given serial width.
    function automatic logic [4:0] cnt_last(input int w);
        return 5'(32 - w);
    endfunction

endpackage

// File: rtl/serv_csr_seq_if.sv
// Request/strobe bundle between the decoder side (master) and the sequencer (slave).
// Handshake: i_req is held until o_ack pulses; a word runs from the cycle after o_ack.
interface serv_csr_seq_if;
    import serv_csr_seq_pkg::*;

    logic   i_req;
    logic   i_csr_op;
    logic   i_mret_op;
    logic   i_exc;
    logic   i_irq;
    logic   i_stall;
    logic   o_ack;
    logic   o_busy;
    logic   o_en;
    logic   o_cnt0to3;
    logic   o_cnt3;
    logic   o_cnt7;
    logic   o_cnt_done;
    logic   o_trap;
    logic   o_mret;
    logic   o_done;
    state_t o_state;

    modport master (
        output i_req, i_csr_op, i_mret_op, i_exc, i_irq, i_stall,
        input  o_ack, o_busy, o_en, o_cnt0to3, o_cnt3, o_cnt7, o_cnt_done,
               o_trap, o_mret, o_done, o_state
    );

    modport slave (
        input  i_req, i_csr_op, i_mret_op, i_exc, i_irq, i_stall,
        output o_ack, o_busy, o_en, o_cnt0to3, o_cnt3, o_cnt7, o_cnt_done,
               o_trap, o_mret, o_done, o_state
    );

endinterface

// File: rtl/serv_csr_bitcnt.sv
// Serial bit-position counter: advances by W on each running cycle and decodes
// which chunk carries bits 0..3, 3, 7 and the last bit of the word.
module serv_csr_bitcnt
    import serv_csr_seq_pkg::*;
#(
    parameter int    W              = 1,
    parameter string RESET_STRATEGY = "MINI"
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_cnt0to3,
    output logic o_cnt3,
    output logic o_cnt7,
    output logic o_cnt_done
);

    localparam logic [4:0] STEP    = 5'(W);
    localparam logic [4:0] MASK    = ~(STEP - 5'd1);
    localparam logic [4:0] LAST    = cnt_last(W);
    localparam bit         RST_CNT = (RESET_STRATEGY != "NONE");

    logic [4:0] r_cnt;

    // Chunks are W-aligned, so a bit lives in the chunk whose masked index matches.
    always_ff @(posedge i_clk) begin
        if ((RST_CNT && i_rst) || i_clr) begin
            r_cnt <= 5'd0;
        end else if (i_run) begin
            r_cnt <= r_cnt + STEP;
        end
    end

    assign o_cnt0to3  = i_run && (r_cnt < 5'd4);
    assign o_cnt3     = i_run && ((r_cnt & MASK) == (5'd3 & MASK));
    assign o_cnt7     = i_run && ((r_cnt & MASK) == (5'd7 & MASK));
    assign o_cnt_done = i_run && (r_cnt == LAST);

endmodule

// File: rtl/serv_csr_seq.sv
// CSR/trap sequencer: accepts one boundary request, arbitrates exception/irq/mret/CSR
// and runs one 32-bit serial word, pulsing o_done the cycle after the last chunk.
module serv_csr_seq
    import serv_csr_seq_pkg::*;
#(
    parameter int    W              = 1,
    parameter string RESET_STRATEGY = "MINI"
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serv_csr_seq_if.slave   bus
);

    localparam bit RST_DONE = (RESET_STRATEGY != "NONE");

    state_t r_state;
    state_t w_next;
    logic   r_done;
    logic   w_done_next;
    logic   w_ack;
    logic   w_active;
    logic   w_run;
    logic   w_cnt_done;

    assign w_active = (r_state != ST_IDLE);
    assign w_run    = w_active && !bus.i_stall;
    // The o_done cycle blocks acceptance so consecutive words are always separated.
    assign w_ack    = (r_state == ST_IDLE) && bus.i_req && !r_done && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (RST_DONE && i_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ack) begin
                    if (bus.i_exc || bus.i_irq) begin
                        w_next = ST_TRAP;
                    end else if (bus.i_mret_op) begin
                        w_next = ST_MRET;
                    end else if (bus.i_csr_op) begin
                        w_next = ST_CSR;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            default: begin
                if (w_cnt_done) begin
                    w_next      = ST_IDLE;
                    w_done_next = 1'b1;
                end
            end
        endcase
    end

    serv_csr_bitcnt #(
        .W              (W),
        .RESET_STRATEGY (RESET_STRATEGY)
    ) u_bitcnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_ack),
        .i_run      (w_run),
        .o_cnt0to3  (bus.o_cnt0to3),
        .o_cnt3     (bus.o_cnt3),
        .o_cnt7     (bus.o_cnt7),
        .o_cnt_done (w_cnt_done)
    );

    assign bus.o_ack      = w_ack;
    assign bus.o_busy     = w_active;
    assign bus.o_en       = w_run;
    assign bus.o_cnt_done = w_cnt_done;
    assign bus.o_trap     = (r_state == ST_TRAP);
    assign bus.o_mret     = (r_state == ST_MRET);
    assign bus.o_done     = r_done;
    assign bus.o_state    = r_state;

endmodule
